io_port_sequencer: RTL and testbench

IO_PORT_SEQUENCER -- requirements
Module: io_port_sequencer

---
 rtl/io_port_sequencer_pkg.sv | 15 +
 rtl/io_onehot_dec.sv | 18 +
 rtl/io_port_sequencer.sv | 97 +++++++++
 tb/tb_io_port_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_port_sequencer_pkg.sv
// Shared types and default sizing for the I/O port sequencer.
package io_port_sequencer_pkg;

  localparam int IO_N   = 4;
  localparam int IO_M   = 1 << IO_N;
  localparam int IO_TMO = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD
  } io_state_t;

endpackage

// File: rtl/io_onehot_dec.sv
// Combinational N-to-M one-hot decoder for the port select bus.
module io_onehot_dec
  import io_port_sequencer_pkg::*;
#(
  parameter int N = IO_N,
  parameter int M = IO_M
) (
  input  logic [N-1:0] addr,
  output logic [M-1:0] sel
);

  // NOTE: assigning a default before the indexed write keeps this block free of latches.
  always_comb begin
    sel       = '0;
    sel[addr] = 1'b1;
  end

endmodule

// File: rtl/io_port_sequencer.sv
// Sequences one CPU I/O request into a SETUP/ACCESS/HOLD bus cycle on a
// one-hot selected peripheral port, with an acknowledge timeout.
module io_port_sequencer
  import io_port_sequencer_pkg::*;
#(
  parameter int N   = IO_N,
  parameter int M   = IO_M,
  parameter int TMO = IO_TMO
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         io_req,
  input  logic         io_we,
  input  logic [N-1:0] io_addr,
  input  logic [3:0]   io_wdata,
  output logic         io_busy,
  output logic         io_done,
  output logic         io_err,
  output logic [3:0]   io_rdata,
  output logic [M-1:0] port_sel,
  output logic         port_wr,
  output logic         port_rd,
  output logic [3:0]   port_wdata,
  input  logic [3:0]   port_rdata,
  input  logic         port_ack
);

  io_state_t   state, state_nxt;
  logic        we_q;
  logic        err_q;
  logic [3:0]  wait_cnt;
  logic [M-1:0] sel_dec;
  logic        start;
  logic        acc_ack;
  logic        acc_tmo;

  io_onehot_dec #(.N(N), .M(M)) u_dec (
    .addr (io_addr),
    .sel  (sel_dec)
  );

  assign start   = (state == IDLE) && io_req;
  assign acc_ack = (state == ACCESS) && port_ack;
  // An ack arriving on the last allowed cycle takes priority over the timeout.
  assign acc_tmo = (state == ACCESS) && !port_ack && (wait_cnt == 4'(TMO - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (io_req) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (acc_ack || acc_tmo) state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_sel   <= '0;
      port_wdata <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      wait_cnt   <= '0;
      io_rdata   <= '0;
    end else begin
      if (start) begin
        port_sel   <= sel_dec;
        port_wdata <= io_wdata;
        we_q       <= io_we;
        err_q      <= 1'b0;
      end else if (state == HOLD) begin
        port_sel <= '0;
      end

      if (state == SETUP)       wait_cnt <= '0;
      else if (state == ACCESS) wait_cnt <= wait_cnt + 4'd1;

      if (acc_ack && !we_q) io_rdata <= port_rdata;
      if (acc_tmo)          err_q    <= 1'b1;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign io_busy = (state != IDLE);
  assign io_done = (state == HOLD);
  assign io_err  = (state == HOLD) && err_q;
  assign port_wr = (state == ACCESS) && we_q;
  assign port_rd = (state == ACCESS) && !we_q;

endmodule

// File: tb/tb_io_port_sequencer.sv
// Directed self-checking bench for io_port_sequencer.
module tb_io_port_sequencer;

  logic        clk;
  logic        reset;
  logic        io_req;
  logic        io_we;
  logic [3:0]  io_addr;
  logic [3:0]  io_wdata;
  logic        io_busy;
  logic        io_done;
  logic        io_err;
  logic [3:0]  io_rdata;
  logic [15:0] port_sel;
  logic        port_wr;
  logic        port_rd;
  logic [3:0]  port_wdata;
  logic [3:0]  port_rdata;
  logic        port_ack;

  int errors = 0;
  int checks = 0;

  int          wr_cnt;
  int          rd_cnt;
  int          done_at;
  logic        err_at_done;
  logic        strobe_clash;
  logic        multi_sel;
  logic [15:0] setup_sel;
  logic [3:0]  setup_wdata;

  io_port_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .io_req     (io_req),
    .io_we      (io_we),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_busy    (io_busy),
    .io_done    (io_done),
    .io_err     (io_err),
    .io_rdata   (io_rdata),
    .port_sel   (port_sel),
    .port_wr    (port_wr),
    .port_rd    (port_rd),
    .port_wdata (port_wdata),
    .port_rdata (port_rdata),
    .port_ack   (port_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues a request at the current falling edge and watches up to 40 cycles.
  // Cycle k is observed at the k-th falling edge after the sampling edge.
  task automatic run_txn(input logic we, input logic [3:0] addr, input logic [3:0] wdata,
                         input logic [3:0] rdata, input int ack_at, input int extra_req_at,
                         input logic hold_req);
    wr_cnt = 0; rd_cnt = 0; done_at = -1; err_at_done = 1'b0;
    strobe_clash = 1'b0; multi_sel = 1'b0; setup_sel = '0; setup_wdata = '0;
    io_req = 1'b1; io_we = we; io_addr = addr; io_wdata = wdata;
    port_rdata = rdata; port_ack = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (port_wr) wr_cnt++;
      if (port_rd) rd_cnt++;
      if (port_wr && port_rd) strobe_clash = 1'b1;
      if ($countones(port_sel) > 1) multi_sel = 1'b1;
      if (k == 1) begin
        setup_sel   = port_sel;
        setup_wdata = port_wdata;
      end
      if (!hold_req && (k == 1 || k == extra_req_at + 1)) io_req = 1'b0;
      if (k == extra_req_at) io_req = 1'b1;
      port_ack = (ack_at >= 0) && (k == ack_at + 2);
      if (io_done) begin
        done_at     = k;
        err_at_done = io_err;
        break;
      end
    end
    port_ack = 1'b0;
    if (done_at < 0) check("done_within_budget", 32'd0, 32'd1);
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check({tag, "_busy"}, io_busy, 1'b0);
    check({tag, "_sel"}, port_sel, 16'h0000);
  endtask

  initial begin
    int extra_done;
    reset = 1'b1; io_req = 1'b0; io_we = 1'b0; io_addr = '0; io_wdata = '0;
    port_rdata = '0; port_ack = 1'b0;

    #2;
    check("rst_busy", io_busy, 1'b0);
    check("rst_done", io_done, 1'b0);
    check("rst_err", io_err, 1'b0);
    check("rst_rdata", io_rdata, 4'h0);
    check("rst_sel", port_sel, 16'h0000);
    check("rst_strobes", {port_wr, port_rd}, 2'b00);
    check("rst_wdata", port_wdata, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Write, ack in first ACCESS cycle.
    run_txn(1'b1, 4'd5, 4'hA, 4'h0, 0, -1, 1'b0);
    check("wr_setup_sel", setup_sel, 16'h0020);
    check("wr_setup_wdata", setup_wdata, 4'hA);
    check("wr_strobe_cycles", wr_cnt, 1);
    check("wr_no_rd", rd_cnt, 0);
    check("wr_done_cycle", done_at, 3);
    check("wr_err", err_at_done, 1'b0);
    expect_idle("wr_after");

    // Read, ack after three wait cycles.
    run_txn(1'b0, 4'd15, 4'h0, 4'h7, 3, -1, 1'b0);
    check("rd_setup_sel", setup_sel, 16'h8000);
    check("rd_strobe_cycles", rd_cnt, 4);
    check("rd_no_wr", wr_cnt, 0);
    check("rd_done_cycle", done_at, 6);
    check("rd_err", err_at_done, 1'b0);
    check("rd_rdata", io_rdata, 4'h7);
    expect_idle("rd_after");

    // Timeout with no ack; read data must not be captured.
    run_txn(1'b0, 4'd2, 4'h0, 4'h3, -1, -1, 1'b0);
    check("tmo_strobe_cycles", rd_cnt, 8);
    check("tmo_done_cycle", done_at, 10);
    check("tmo_err", err_at_done, 1'b1);
    check("tmo_rdata_kept", io_rdata, 4'h7);
    expect_idle("tmo_after");

    // Ack on the final timeout cycle, plus an ignored request pulse while busy.
    run_txn(1'b0, 4'd9, 4'h0, 4'hC, 7, 4, 1'b0);
    check("last_strobe_cycles", rd_cnt, 8);
    check("last_done_cycle", done_at, 10);
    check("last_err", err_at_done, 1'b0);
    check("last_rdata", io_rdata, 4'hC);
    extra_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (io_busy || io_done) extra_done++;
    end
    check("busy_req_ignored", extra_done, 0);

    // Request held high across HOLD exit gives a back-to-back transaction.
    run_txn(1'b1, 4'd0, 4'h3, 4'h0, 0, -1, 1'b1);
    check("b2b_first_done", done_at, 3);
    @(negedge clk);
    check("b2b_idle_gap", io_busy, 1'b0);
    @(negedge clk);
    check("b2b_restart_busy", io_busy, 1'b1);
    check("b2b_restart_sel", port_sel, 16'h0001);
    io_req = 1'b0; port_ack = 1'b1;
    @(negedge clk);
    check("b2b_wr", port_wr, 1'b1);
    @(negedge clk);
    check("b2b_done", io_done, 1'b1);
    port_ack = 1'b0;
    expect_idle("b2b_after");

    // Reset in the middle of ACCESS.
    io_req = 1'b1; io_we = 1'b0; io_addr = 4'd3;
    @(negedge clk);
    io_req = 1'b0;
    @(negedge clk);
    check("mid_rd_active", port_rd, 1'b1);
    check("mid_sel_active", port_sel, 16'h0008);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_sel", port_sel, 16'h0000);
    check("mid_rst_strobes", {port_wr, port_rd}, 2'b00);
    check("mid_rst_busy", io_busy, 1'b0);
    check("mid_rst_rdata", io_rdata, 4'h0);
    extra_done = 0;
    @(negedge clk);
    if (io_done) extra_done++;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (io_done) extra_done++;
    end
    check("mid_rst_no_done", extra_done, 0);

    run_txn(1'b1, 4'd6, 4'h5, 4'h0, 1, -1, 1'b0);
    check("post_rst_sel", setup_sel, 16'h0040);
    check("post_rst_wdata", setup_wdata, 4'h5);
    check("post_rst_strobe_cycles", wr_cnt, 2);
    check("post_rst_done_cycle", done_at, 4);
    check("post_rst_err", err_at_done, 1'b0);
    expect_idle("post_rst_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Structural properties sampled on every falling edge for the whole run.
  always @(negedge clk) begin
    if (!reset) begin
      if ($countones(port_sel) > 1) begin
        errors++;
        $display("FAIL sel_onehot: got 0x%0h expected at most one bit", port_sel);
      end
      if (port_wr && port_rd) begin
        errors++;
        $display("FAIL strobe_exclusive: got wr=%0b rd=%0b expected not both", port_wr, port_rd);
      end
    end
  end

endmodule
